// File: rtl/mp_arith_pkg.sv
// Shared opcodes, FSM state type and opcode decode for the multi-precision
// arithmetic sequencer.
package mp_arith_pkg;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00101;
  localparam logic [4:0] OP_INC = 5'b00011;
  localparam logic [4:0] OP_DEC = 5'b00110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  function automatic logic op_supported(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/arith_slice.sv
// One BITS-wide add step with carry in/out; ovf is only meaningful when the
// slice is fed the most-significant word.
module arith_slice #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] sum,
  output logic            cout,
  output logic            ovf
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, cin};
  assign ovf = (a[BITS-1] == b[BITS-1]) && (sum[BITS-1] != a[BITS-1]);

endmodule

// File: rtl/mp_arith_ctrl.sv
// Word-serial WORDS x BITS add/sub/inc/dec sequencer: one slice, LS word first,
// carry chained through a register; flags reflect the full-width result.
module mp_arith_ctrl
  import mp_arith_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [4:0]            OP,
  input  logic [BITS*WORDS-1:0] A_IN,
  input  logic [BITS*WORDS-1:0] B_IN,
  output logic [BITS*WORDS-1:0] RESU,
  output logic                  O,
  output logic                  C,
  output logic                  S,
  output logic                  Z,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR
);

  localparam int W  = BITS * WORDS;
  localparam int KW = $clog2(WORDS);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
  logic [KW-1:0]   k_q, k_d;
  logic [BITS-1:0] acc_q, acc_d;
  logic            cy_q, cy_d;
  logic            o_q, o_d, c_q, c_d, s_q, s_d, z_q, z_d;
  logic            done_q, done_d, err_q, err_d;

  logic [BITS-1:0] sum;
  logic            cout, ovf;

  // Operands shift right each step, so the slice always sees the current word.
  arith_slice #(.BITS(BITS)) u_slice (
    .a   (a_q[BITS-1:0]),
    .b   (b_q[BITS-1:0]),
    .cin (cy_q),
    .sum (sum),
    .cout(cout),
    .ovf (ovf)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    k_d     = k_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    o_d     = o_q;
    c_d     = c_q;
    s_d     = s_q;
    z_d     = z_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          if (op_supported(OP)) begin
            state_d = RUN;
            a_d     = A_IN;
            k_d     = '0;
            acc_d   = '0;
            // Subtraction becomes A + ~B + 1; inc/dec substitute a constant B.
            case (OP)
              OP_ADD:  begin b_d = B_IN;  cy_d = 1'b0; end
              OP_SUB:  begin b_d = ~B_IN; cy_d = 1'b1; end
              OP_INC:  begin b_d = '0;    cy_d = 1'b1; end
              default: begin b_d = '1;    cy_d = 1'b0; end
            endcase
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        a_d                      = a_q >> BITS;
        b_d                      = b_q >> BITS;
        cy_d                     = cout;
        res_d[k_q*BITS +: BITS]  = sum;
        acc_d                    = acc_q | sum;
        k_d                      = k_q + 1'b1;
        if (k_q == KW'(WORDS - 1)) begin
          state_d = FIN;
          o_d     = ovf;
          c_d     = cout;
          s_d     = sum[BITS-1];
          z_d     = ~|(acc_q | sum);
        end
      end
      FIN: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      o_q     <= 1'b0;
      c_q     <= 1'b0;
      s_q     <= 1'b0;
      z_q     <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      o_q     <= o_d;
      c_q     <= c_d;
      s_q     <= s_d;
      z_q     <= z_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign RESU = res_q;
  assign O    = o_q;
  assign C    = c_q;
  assign S    = s_q;
  assign Z    = z_q;
  assign BUSY = (state_q == RUN);
  assign DONE = done_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_mp_arith_ctrl.sv
// Self-checking bench for mp_arith_ctrl: directed corner cases plus random
// operations compared against a full-width integer reference model.
module tb_mp_arith_ctrl;
  import mp_arith_pkg::*;

  localparam int BITS  = 8;
  localparam int WORDS = 4;
  localparam int W     = BITS * WORDS;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [4:0]   OP;
  logic [W-1:0] A_IN, B_IN, RESU;
  logic         O, C, S, Z, BUSY, DONE, ERR;

  int n_checks = 0;
  int n_errors = 0;

  mp_arith_ctrl #(.BITS(BITS), .WORDS(WORDS)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .START(START),
    .OP   (OP),
    .A_IN (A_IN),
    .B_IN (B_IN),
    .RESU (RESU),
    .O    (O),
    .C    (C),
    .S    (S),
    .Z    (Z),
    .BUSY (BUSY),
    .DONE (DONE),
    .ERR  (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed/unsigned integer arithmetic on the whole operand.
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic o, output logic c);
    longint sa, sb, ua, ub, exact, maxu, maxs, mins;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ua   = longint'(a);
    ub   = longint'(b);
    maxu = (longint'(1) <<< W) - 1;
    maxs = (longint'(1) <<< (W - 1)) - 1;
    mins = -(longint'(1) <<< (W - 1));
    case (op)
      OP_ADD:  begin exact = sa + sb; c = (ua + ub) > maxu; end
      OP_SUB:  begin exact = sa - sb; c = (ua >= ub);       end
      OP_INC:  begin exact = sa + 1;  c = (ua == maxu);     end
      default: begin exact = sa - 1;  c = (ua != 0);        end
    endcase
    r = exact[W-1:0];
    o = (exact > maxs) || (exact < mins);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ":resu"}, 64'(RESU), 64'd0);
    check({tag, ":o"},    64'(O),    64'd0);
    check({tag, ":c"},    64'(C),    64'd0);
    check({tag, ":s"},    64'(S),    64'd0);
    check({tag, ":z"},    64'(Z),    64'd1);
    check({tag, ":busy"}, 64'(BUSY), 64'd0);
    check({tag, ":done"}, 64'(DONE), 64'd0);
    check({tag, ":err"},  64'(ERR),  64'd0);
  endtask

  // Issues one operation and returns in the DONE cycle, so a following call
  // drives START into the first IDLE cycle.
  task automatic do_op(input string tag, input logic [4:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit noisy);
    logic [W-1:0] er;
    logic         eo, ec;
    logic [4:0]   ops [4];
    int           cyc, busy_n, err_n;
    ops = '{OP_ADD, OP_SUB, OP_INC, OP_DEC};
    model(op, a, b, er, eo, ec);
    START = 1'b1; OP = op; A_IN = a; B_IN = b;
    tick();
    START = 1'b0; A_IN = $urandom; B_IN = $urandom;
    cyc = 0; busy_n = 0; err_n = 0;
    while (DONE !== 1'b1 && cyc < 20) begin
      if (BUSY === 1'b1) busy_n++;
      if (ERR === 1'b1) err_n++;
      START = (noisy && BUSY === 1'b1);
      if (START) begin
        OP = ops[$urandom_range(0, 3)];
        A_IN = $urandom; B_IN = $urandom;
      end
      tick();
      cyc++;
    end
    START = 1'b0;
    check({tag, ":latency"}, 64'(cyc),    64'(WORDS + 1));
    check({tag, ":busy_n"},  64'(busy_n), 64'(WORDS));
    check({tag, ":err_n"},   64'(err_n),  64'd0);
    check({tag, ":resu"},    64'(RESU),   64'(er));
    check({tag, ":flags"},   64'({O, C, S, Z}), 64'({eo, ec, er[W-1], (er == '0)}));
  endtask

  initial begin : main
    logic [W-1:0] corner [4];
    logic [W-1:0] prev_r, ra, rb;
    logic [3:0]   prev_f;
    logic [4:0]   ops [4];
    int           done_n;
    corner = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    ops    = '{OP_ADD, OP_SUB, OP_INC, OP_DEC};

    RST_N = 1'b0; START = 1'b0; OP = '0; A_IN = '0; B_IN = '0;
    #12;
    check_reset_vals("reset");
    RST_N = 1'b1;

    do_op("add_ff_1",   OP_ADD, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    do_op("add_ovf",    OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    do_op("inc_wrap",   OP_INC, 32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
    do_op("sub_eq",     OP_SUB, 32'h1234_5678, 32'h1234_5678, 1'b0);
    do_op("sub_ovf",    OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0);
    do_op("dec_zero",   OP_DEC, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0);
    do_op("b2b_add",    OP_ADD, 32'h0123_4567, 32'h89AB_CDEF, 1'b0);
    do_op("noisy_sub",  OP_SUB, 32'h0000_0010, 32'h0000_0020, 1'b1);

    // Unsupported opcode: ERR one cycle later, nothing else moves.
    tick();
    prev_r = RESU; prev_f = {O, C, S, Z};
    START = 1'b1; OP = 5'b01010; A_IN = $urandom; B_IN = $urandom;
    tick();
    START = 1'b0;
    check("bad_op:err",  64'(ERR),  64'd1);
    check("bad_op:busy", 64'(BUSY), 64'd0);
    tick();
    check("bad_op:err_pulse", 64'(ERR),  64'd0);
    check("bad_op:busy2",     64'(BUSY), 64'd0);
    check("bad_op:done",      64'(DONE), 64'd0);
    check("bad_op:resu",      64'(RESU), 64'(prev_r));
    check("bad_op:flags",     64'({O, C, S, Z}), 64'(prev_f));

    // Reset during the second RUN cycle discards the operation.
    START = 1'b1; OP = OP_ADD; A_IN = 32'h1111_1111; B_IN = 32'h2222_2222;
    tick();
    START = 1'b0;
    tick();
    #2 RST_N = 1'b0;
    #1 check_reset_vals("mid_reset");
    tick();
    tick();
    RST_N = 1'b1;
    done_n = 0;
    for (int i = 0; i < 10; i++) begin
      if (DONE === 1'b1) done_n++;
      tick();
    end
    check("mid_reset:no_done", 64'(done_n), 64'd0);
    do_op("post_reset_add", OP_ADD, 32'h1111_1111, 32'h2222_2222, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
      do_op($sformatf("rand%0d", i), ops[$urandom_range(0, 3)], ra, rb, ($urandom_range(0, 3) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
